// File: rtl/id_stage_p.sv
// MIPS-style decode stage: register file with write-back bypass, control decode,
// load-use interlock and the registered ID/EX boundary.
module id_stage_p #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   localparam int RW  = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   input  logic [31:0]     if_ins,
   input  logic [XLEN-1:0] if_pc,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [RW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            if_stall,
   output logic            id_valid,
   output logic [8:0]      id_ctrl,
   output logic [XLEN-1:0] id_r1,
   output logic [XLEN-1:0] id_r2,
   output logic [XLEN-1:0] id_imm,
   output logic [XLEN-1:0] id_jaddr,
   output logic [5:0]      id_func,
   output logic [RW-1:0]   id_wreg,
   output logic [RW-1:0]   id_rs,
   output logic [RW-1:0]   id_rt,
   output logic [XLEN-1:0] id_pc,
   output logic [15:0]     stall_cnt
);

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08;

   // ctrl = {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp[1:0]}
   localparam int C_REGDST  = 8;
   localparam int C_MEMREAD = 4;

   typedef struct packed {
      logic            vld;
      logic [8:0]      ctrl;
      logic [XLEN-1:0] r1;
      logic [XLEN-1:0] r2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] jaddr;
      logic [5:0]      func;
      logic [RW-1:0]   wreg;
      logic [RW-1:0]   rs;
      logic [RW-1:0]   rt;
      logic [XLEN-1:0] pc;
   } bndl_t;

   logic [NREG-1:0][XLEN-1:0] rf;
   logic [5:0]    opc;
   logic [RW-1:0] rs, rt, rd;
   logic [8:0]    ctrl;
   logic          wb_hit;
   logic          haz;
   bndl_t         dec, bndl;

   assign opc    = if_ins[31:26];
   assign rs     = if_ins[21 +: RW];
   assign rt     = if_ins[16 +: RW];
   assign rd     = if_ins[11 +: RW];
   assign wb_hit = wb_en && (wb_rd != '0);

   always_comb begin
      ctrl = 9'h000;
      case (opc)
         OP_R:    ctrl = 9'h122;
         OP_LW:   ctrl = 9'h0F0;
         OP_SW:   ctrl = 9'h088;
         OP_BEQ:  ctrl = 9'h005;
         OP_ADDI: ctrl = 9'h0A0;
         default: ctrl = 9'h000;
      endcase
   end

   // Same-cycle write-back is forwarded so the read never sees a stale value.
   function automatic logic [XLEN-1:0] rd_port(input logic [RW-1:0] idx);
      if (idx == '0)
         return '0;
      else if (wb_hit && (wb_rd == idx))
         return wb_data;
      else
         return rf[idx];
   endfunction

   always_comb begin
      dec       = '0;
      dec.vld   = 1'b1;
      dec.ctrl  = ctrl;
      dec.r1    = rd_port(rs);
      dec.r2    = rd_port(rt);
      dec.imm   = {{(XLEN-16){if_ins[15]}}, if_ins[15:0]};
      dec.jaddr = {{(XLEN-26){if_ins[25]}}, if_ins[25:0]};
      dec.func  = (opc == OP_R) ? if_ins[5:0] : opc;
      dec.wreg  = ctrl[C_REGDST] ? rd : rt;
      dec.rs    = rs;
      dec.rt    = rt;
      dec.pc    = if_pc;
   end

   // rt is compared for every opcode, even those that never read it.
   assign haz = if_valid && bndl.vld && bndl.ctrl[C_MEMREAD] && (bndl.wreg != '0)
                && ((bndl.wreg == rs) || (bndl.wreg == rt));
   assign if_stall = haz && !flush && !rst;

   always_ff @(posedge clk) begin
      if (rst)
         rf <= '0;
      else if (wb_hit)
         rf[wb_rd] <= wb_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bndl      <= '0;
         stall_cnt <= '0;
      end else if (flush) begin
         bndl <= '0;
      end else if (haz) begin
         bndl <= '0;
         if (stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end else if (!if_valid) begin
         bndl <= '0;
      end else begin
         bndl <= dec;
      end
   end

   assign id_valid = bndl.vld;
   assign id_ctrl  = bndl.ctrl;
   assign id_r1    = bndl.r1;
   assign id_r2    = bndl.r2;
   assign id_imm   = bndl.imm;
   assign id_jaddr = bndl.jaddr;
   assign id_func  = bndl.func;
   assign id_wreg  = bndl.wreg;
   assign id_rs    = bndl.rs;
   assign id_rt    = bndl.rt;
   assign id_pc    = bndl.pc;

endmodule

// File: tb/tb_id_stage_p.sv
// Directed bench for id_stage_p: default 32-bit instance plus a 64-bit/16-register instance.
module tb_id_stage_p;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---- instance a: XLEN=32, NREG=32
   logic        a_rst, a_ifv, a_flush, a_wbe;
   logic [31:0] a_ins, a_pc, a_wbd;
   logic [4:0]  a_wbr;
   logic        a_stall, a_vld;
   logic [8:0]  a_ctrl;
   logic [31:0] a_r1, a_r2, a_imm, a_jaddr, a_idpc;
   logic [5:0]  a_func;
   logic [4:0]  a_wreg, a_rs, a_rt;
   logic [15:0] a_scnt;

   id_stage_p dut_a (
      .clk(clk), .rst(a_rst), .if_valid(a_ifv), .if_ins(a_ins), .if_pc(a_pc),
      .flush(a_flush), .wb_en(a_wbe), .wb_rd(a_wbr), .wb_data(a_wbd),
      .if_stall(a_stall), .id_valid(a_vld), .id_ctrl(a_ctrl), .id_r1(a_r1), .id_r2(a_r2),
      .id_imm(a_imm), .id_jaddr(a_jaddr), .id_func(a_func), .id_wreg(a_wreg),
      .id_rs(a_rs), .id_rt(a_rt), .id_pc(a_idpc), .stall_cnt(a_scnt)
   );

   // ---- instance b: XLEN=64, NREG=16
   logic        b_rst, b_ifv, b_flush, b_wbe;
   logic [31:0] b_ins;
   logic [63:0] b_pc, b_wbd;
   logic [3:0]  b_wbr;
   logic        b_stall, b_vld;
   logic [8:0]  b_ctrl;
   logic [63:0] b_r1, b_r2, b_imm, b_jaddr, b_idpc;
   logic [5:0]  b_func;
   logic [3:0]  b_wreg, b_rs, b_rt;
   logic [15:0] b_scnt;

   id_stage_p #(.XLEN(64), .NREG(16)) dut_b (
      .clk(clk), .rst(b_rst), .if_valid(b_ifv), .if_ins(b_ins), .if_pc(b_pc),
      .flush(b_flush), .wb_en(b_wbe), .wb_rd(b_wbr), .wb_data(b_wbd),
      .if_stall(b_stall), .id_valid(b_vld), .id_ctrl(b_ctrl), .id_r1(b_r1), .id_r2(b_r2),
      .id_imm(b_imm), .id_jaddr(b_jaddr), .id_func(b_func), .id_wreg(b_wreg),
      .id_rs(b_rs), .id_rt(b_rt), .id_pc(b_idpc), .stall_cnt(b_scnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   initial begin
      a_rst = 1; a_ifv = 0; a_ins = 0; a_pc = 0; a_flush = 0; a_wbe = 0; a_wbr = 0; a_wbd = 0;
      b_rst = 1; b_ifv = 0; b_ins = 0; b_pc = 0; b_flush = 0; b_wbe = 0; b_wbr = 0; b_wbd = 0;
      tick(); tick();

      // reset state
      chk("rst_valid", a_vld, 0);
      chk("rst_ctrl", a_ctrl, 0);
      chk("rst_r1", a_r1, 0);
      chk("rst_scnt", a_scnt, 0);
      chk("rst_stall", a_stall, 0);

      // write $1=5, $2=7 then add $3,$1,$2
      a_rst = 0;
      a_wbe = 1; a_wbr = 1; a_wbd = 5; tick();
      a_wbr = 2; a_wbd = 7; tick();
      a_wbe = 0; a_ifv = 1; a_ins = 32'h0022_1820; a_pc = 32'h100; tick();
      chk("add_valid", a_vld, 1);
      chk("add_ctrl", a_ctrl, 9'h122);
      chk("add_r1", a_r1, 5);
      chk("add_r2", a_r2, 7);
      chk("add_wreg", a_wreg, 3);
      chk("add_func", a_func, 6'h20);
      chk("add_pc", a_idpc, 32'h100);

      // same-cycle write-back bypass into rs
      a_wbe = 1; a_wbr = 1; a_wbd = 32'hAA; tick();
      chk("byp_r1", a_r1, 32'hAA);
      chk("byp_r2", a_r2, 7);
      // write to $0 is dropped; $1 keeps the bypassed value from the register file
      a_wbr = 0; a_wbd = 32'hFF; a_ins = 32'h0020_1820; tick();
      chk("rf_r1", a_r1, 32'hAA);
      chk("r0_r2", a_r2, 0);
      a_wbe = 0; a_ins = 32'h0000_1820; tick();
      chk("r0_read", a_r1, 0);

      // load-use: lw $4,0($1) then add $5,$4,$2
      a_ins = 32'h8C24_0000; tick();
      chk("lw_ctrl", a_ctrl, 9'h0F0);
      chk("lw_wreg", a_wreg, 4);
      a_ins = 32'h0082_2820; #1;
      chk("lu_stall", a_stall, 1);
      tick();
      chk("lu_bub_valid", a_vld, 0);
      chk("lu_bub_ctrl", a_ctrl, 0);
      chk("lu_scnt", a_scnt, 1);
      chk("lu_stall_drop", a_stall, 0);
      tick();
      chk("lu_issue_valid", a_vld, 1);
      chk("lu_issue_wreg", a_wreg, 5);
      chk("lu_issue_r2", a_r2, 7);
      chk("lu_issue_r1", a_r1, 0);

      // lw into $0 never interlocks
      a_ins = 32'h8C20_0000; tick();
      a_ins = 32'h0002_2820; #1;
      chk("lw0_stall", a_stall, 0);
      tick();
      chk("lw0_valid", a_vld, 1);
      chk("lw0_scnt", a_scnt, 1);

      // addi $6,$1,-2
      a_ins = 32'h2026_FFFE; tick();
      chk("addi_imm", a_imm, 32'hFFFF_FFFE);
      chk("addi_ctrl", a_ctrl, 9'h0A0);
      chk("addi_wreg", a_wreg, 6);
      chk("addi_func", a_func, 6'h08);
      chk("addi_jaddr", a_jaddr, 32'h0026_FFFE);

      // unknown opcode 0x3F still marks the bundle valid
      a_ins = 32'hFE00_0000; tick();
      chk("unk_ctrl", a_ctrl, 0);
      chk("unk_func", a_func, 6'h3F);
      chk("unk_valid", a_vld, 1);
      chk("unk_jaddr", a_jaddr, 32'hFE00_0000);

      // flush in the hazard cycle beats the stall
      a_ins = 32'h8C24_0000; tick();
      a_ins = 32'h0082_2820; a_flush = 1; #1;
      chk("fl_stall", a_stall, 0);
      tick();
      chk("fl_valid", a_vld, 0);
      chk("fl_ctrl", a_ctrl, 0);
      chk("fl_scnt", a_scnt, 1);
      a_flush = 0; tick();
      chk("fl_issue_valid", a_vld, 1);
      chk("fl_issue_wreg", a_wreg, 5);

      // no valid instruction -> bubble
      a_ifv = 0; tick();
      chk("nov_valid", a_vld, 0);

      // reset mid-stall clears counter, bundle and registers
      a_ifv = 1; a_ins = 32'h8C24_0000; tick();
      a_ins = 32'h0082_2820; a_rst = 1; #1;
      chk("rs_stall", a_stall, 0);
      tick();
      chk("rs_valid", a_vld, 0);
      chk("rs_scnt", a_scnt, 0);
      a_rst = 0; a_ins = 32'h0022_1820; tick();
      chk("rs_rf_cleared", a_r1, 0);

      // 64-bit / 16-register instance
      b_rst = 0;
      b_wbe = 1; b_wbr = 1; b_wbd = 64'h1_0000_0000; tick();
      b_wbr = 2; b_wbd = 64'h1; tick();
      b_wbe = 0; b_ifv = 1; b_ins = 32'h0222_9820; b_pc = 64'h2_0000_0040; tick();
      chk("w64_r1", b_r1, 64'h1_0000_0000);
      chk("w64_r2", b_r2, 64'h1);
      chk("w64_wreg", b_wreg, 3);
      chk("w64_rs", b_rs, 1);
      chk("w64_pc", b_idpc, 64'h2_0000_0040);
      b_ins = 32'h2026_FFFE; tick();
      chk("w64_imm", b_imm, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("w64_ctrl", b_ctrl, 9'h0A0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
